// File: rtl/mmss_timer.sv
// MM:SS timer with run/pause, up/down count, preset load and wrap/done status,
// driving four seven-segment digits combinationally from the binary time registers.
module mmss_timer #(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mode,
    input  logic       load,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       tick,
    output logic       wrap,
    output logic       done
);

    localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] r_ps;
    logic [5:0]    r_sec;
    logic [5:0]    r_min;
    logic          r_tick;
    logic          r_wrap;
    logic          r_done;

    logic [PW-1:0] w_ps_d;
    logic [5:0]    w_sec_d;
    logic [5:0]    w_min_d;
    logic          w_wrap_d;
    logic          w_done_d;
    logic          w_ps_end;
    logic [5:0]    w_load_sec;
    logic [5:0]    w_load_min;

    assign w_ps_end   = run && (r_ps == PS_MAX);
    assign w_load_sec = (load_sec > 6'd59) ? 6'd59 : load_sec;
    assign w_load_min = (load_min > 6'd59) ? 6'd59 : load_min;

    always_comb begin
        w_ps_d   = r_ps;
        w_sec_d  = r_sec;
        w_min_d  = r_min;
        w_wrap_d = 1'b0;
        w_done_d = r_done;
        if (run) begin
            w_ps_d = w_ps_end ? '0 : r_ps + PW'(1);
        end
        // Load beats a coincident tick: its time, wrap and done effects are dropped.
        if (load) begin
            w_ps_d   = '0;
            w_sec_d  = w_load_sec;
            w_min_d  = w_load_min;
            w_done_d = 1'b0;
        end else if (w_ps_end) begin
            if (!mode) begin
                w_done_d = 1'b0;
                if (r_sec == 6'd59) begin
                    w_sec_d = 6'd0;
                    if (r_min == 6'd59) begin
                        w_min_d  = 6'd0;
                        w_wrap_d = 1'b1;
                    end else begin
                        w_min_d = r_min + 6'd1;
                    end
                end else begin
                    w_sec_d = r_sec + 6'd1;
                end
            end else if (r_sec != 6'd0 || r_min != 6'd0) begin
                if (r_sec == 6'd0) begin
                    w_sec_d = 6'd59;
                    w_min_d = r_min - 6'd1;
                end else begin
                    w_sec_d = r_sec - 6'd1;
                end
                if (r_min == 6'd0 && r_sec == 6'd1) begin
                    w_done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ps   <= '0;
            r_sec  <= 6'd0;
            r_min  <= 6'd0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_ps   <= w_ps_d;
            r_sec  <= w_sec_d;
            r_min  <= w_min_d;
            r_tick <= w_ps_end;
            r_wrap <= w_wrap_d;
            r_done <= w_done_d;
        end
    end

    assign tick = r_tick;
    assign wrap = r_wrap;
    assign done = r_done;

    function automatic logic [6:0] seg7(input logic [5:0] d);
        logic [6:0] p;
        case (d)
            6'd0:    p = 7'b0111111;
            6'd1:    p = 7'b0000110;
            6'd2:    p = 7'b1011011;
            6'd3:    p = 7'b1001111;
            6'd4:    p = 7'b1100110;
            6'd5:    p = 7'b1101101;
            6'd6:    p = 7'b1111101;
            6'd7:    p = 7'b0000111;
            6'd8:    p = 7'b1111111;
            6'd9:    p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    logic [5:0] w_sec_t;
    logic [5:0] w_sec_u;
    logic [5:0] w_min_t;
    logic [5:0] w_min_u;

    assign w_sec_t = r_sec / 6'd10;
    assign w_sec_u = r_sec - w_sec_t * 6'd10;
    assign w_min_t = r_min / 6'd10;
    assign w_min_u = r_min - w_min_t * 6'd10;

    assign hex0 = seg7(w_sec_u);
    assign hex1 = seg7(w_sec_t);
    assign hex2 = seg7(w_min_u);
    assign hex3 = seg7(w_min_t);

endmodule

// File: tb/tb_mmss_timer.sv
// Randomized bench for mmss_timer: a total-seconds reference model plus directed boundary cases.
module tb_mmss_timer;

    localparam int unsigned CLK_HZ = 4;
    localparam logic [6:0] Z   = 7'b1000000;
    localparam logic [6:0] ONE = 7'b1111001;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       mode;
    logic       load;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic       tick, wrap, done;

    int n_err = 0;
    int n_chk = 0;

    // Reference state: time as total seconds 0..3599, prescaler as a phase count.
    int m_t;
    int m_ph;
    bit m_tick;
    bit m_wrap;
    bit m_done;
    logic [6:0] seg_tab [10];

    mmss_timer #(
        .CLK_HZ         (CLK_HZ),
        .SEG_ACTIVE_LOW (1'b1)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .mode     (mode),
        .load     (load),
        .load_min (load_min),
        .load_sec (load_sec),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .tick     (tick),
        .wrap     (wrap),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [27:0] exp_hex(input int t);
        int s = t % 60;
        int m = t / 60;
        return {~seg_tab[m / 10], ~seg_tab[m % 10], ~seg_tab[s / 10], ~seg_tab[s % 10]};
    endfunction

    function automatic int clamp59(input int v);
        return (v > 59) ? 59 : v;
    endfunction

    task automatic model_reset();
        m_t = 0; m_ph = 0; m_tick = 0; m_wrap = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit e = run && (m_ph == CLK_HZ - 1);
        m_tick = e;
        m_wrap = 0;
        if (run) m_ph = e ? 0 : m_ph + 1;
        if (load) begin
            m_t    = clamp59(int'(load_min)) * 60 + clamp59(int'(load_sec));
            m_ph   = 0;
            m_done = 0;
        end else if (e) begin
            if (!mode) begin
                m_done = 0;
                m_wrap = (m_t == 3599);
                m_t    = (m_t + 1) % 3600;
            end else if (m_t > 0) begin
                m_t--;
                if (m_t == 0) m_done = 1;
            end
        end
    endtask

    task automatic check_all();
        check_val("hex",  {4'h0, hex3, hex2, hex1, hex0}, {4'h0, exp_hex(m_t)});
        check_val("tick", {31'h0, tick}, {31'h0, m_tick});
        check_val("wrap", {31'h0, wrap}, {31'h0, m_wrap});
        check_val("done", {31'h0, done}, {31'h0, m_done});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            check_all();
        end
    endtask

    task automatic do_load(input int mn, input int sc, input bit r);
        load     = 1'b1;
        load_min = 6'(mn);
        load_sec = 6'(sc);
        run      = r;
        step(1);
        load     = 1'b0;
    endtask

    initial begin
        seg_tab = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
        reset = 1'b0; run = 1'b0; mode = 1'b0; load = 1'b0;
        load_min = 6'd0; load_sec = 6'd0;
        model_reset();

        // Reset values, then idle with run=0
        #12;
        check_all();
        @(posedge clk); #1;
        reset = 1'b1;
        step(20);
        check_val("idle_hex", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, Z, Z, Z, Z});

        // Up count: first tick after CLK_HZ cycles, 01:00 after 60 ticks
        run = 1'b1; mode = 1'b0;
        step(4);
        check_val("first_tick", {31'h0, tick}, 32'h1);
        check_val("first_hex0", {25'h0, hex0}, {25'h0, ONE});
        step(236);
        check_val("one_min", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, Z, ONE, Z, Z});

        // Wrap 59:59 -> 00:00
        do_load(59, 59, 1'b1);
        step(3);
        check_val("wrap_early", {31'h0, wrap}, 32'h0);
        step(1);
        check_val("wrap_pulse", {30'h0, wrap, tick}, 32'h3);
        check_val("wrap_hex", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, Z, Z, Z, Z});
        step(1);
        check_val("wrap_end", {31'h0, wrap}, 32'h0);

        // Countdown to 00:00 and hold
        mode = 1'b1;
        do_load(0, 2, 1'b1);
        step(8);
        check_val("cd_done", {31'h0, done}, 32'h1);
        check_val("cd_hex", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, Z, Z, Z, Z});
        step(8);
        check_val("cd_hold", {31'h0, done}, 32'h1);
        check_val("cd_hold_hex", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, Z, Z, Z, Z});
        do_load(0, 5, 1'b1);
        check_val("cd_reload", {31'h0, done}, 32'h0);

        // Pause after 2 run-cycles, resume: tick 2 run-cycles later
        mode = 1'b0;
        do_load(0, 0, 1'b1);
        step(2);
        run = 1'b0;
        step(10);
        run = 1'b1;
        begin
            int k = 0;
            bit found = 0;
            while (!found && k < 20) begin
                step(1);
                k++;
                if (tick) found = 1;
            end
            check_val("resume_tick", k, 2);
        end

        // Clamp
        do_load(7, 63, 1'b0);
        check_val("clamp", {4'h0, hex3, hex2, hex1, hex0},
                  {4'h0, ~seg_tab[0], ~seg_tab[7], ~seg_tab[5], ~seg_tab[9]});

        // Load on a tick cycle wins over the 07:59 -> 08:00 increment
        run = 1'b1;
        step(3);
        do_load(12, 34, 1'b1);
        check_val("prio_tick", {30'h0, wrap, tick}, 32'h1);
        check_val("prio_hex", {4'h0, hex3, hex2, hex1, hex0},
                  {4'h0, ~seg_tab[1], ~seg_tab[2], ~seg_tab[3], ~seg_tab[4]});

        // Asynchronous reset between edges
        step(5);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_val("async_hex", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, Z, Z, Z, Z});
        check_all();
        @(posedge clk); #1;
        reset = 1'b1;

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom % 8) != 0;
            if ($urandom % 50 == 0) mode = ~mode;
            if ($urandom % 25 == 0) begin
                case ($urandom % 4)
                    0:       do_load(59, 59, run);
                    1:       do_load(0, $urandom_range(0, 2), run);
                    2:       do_load(int'($urandom % 60), 59, run);
                    default: do_load(int'($urandom % 64), int'($urandom % 64), run);
                endcase
            end else begin
                step(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
